// File: rtl/vec_decrypt_engine_if.sv
// Request/response bus for vec_decrypt_engine.
//   in_valid/in_ready    : request handshake (cipher, key, rounds, shamt)
//   out_valid/out_ready  : result handshake (plain_out)
//   busy                 : engine is in any state other than idle
// master = requester/consumer side, slave = engine side.
interface vec_decrypt_engine_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] cipher_in;
  logic [WIDTH-1:0] key_in;
  logic [3:0]       rounds_in;
  logic [2:0]       shamt_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] plain_out;
  logic             busy;

  modport master (
    output in_valid, cipher_in, key_in, rounds_in, shamt_in, out_ready,
    input  in_ready, out_valid, plain_out, busy
  );

  modport slave (
    input  in_valid, cipher_in, key_in, rounds_in, shamt_in, out_ready,
    output in_ready, out_valid, plain_out, busy
  );
endinterface

// File: rtl/vec_decrypt_engine.sv
// Multi-cycle byte-lane decryption engine.
// Undoes N rounds of (xor byte-0 key, rotate-left by s, add lane key) per byte
// lane, one sub-step per clock, rounds walked from N-1 down to 0.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : vec_decrypt_engine_if.slave (request, result, busy)

// One byte lane: all three inverse sub-step results, selected by the FSM.
module vec_decrypt_lane (
  input  logic [7:0] x,
  input  logic [7:0] rk_lane,
  input  logic [7:0] rk_b0,
  input  logic [2:0] s,
  output logic [7:0] sub,
  output logic [7:0] rotr,
  output logic [7:0] xr
);
  logic [15:0] dbl;

  // Doubling the byte turns the rotate into a plain shift; s=0 is identity.
  assign dbl  = {x, x} >> s;
  assign sub  = x - rk_lane;
  assign rotr = dbl[7:0];
  assign xr   = x ^ rk_b0;
endmodule

module vec_decrypt_engine #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  vec_decrypt_engine_if.slave  bus
);
  localparam int NUM_LANES = WIDTH / 8;

  typedef enum logic [2:0] {IDLE, SUBK, ROTR, XORK, DONE} state_t;

  state_t                      state;
  logic [3:0]                  ctr;
  logic [2:0]                  shamt;
  logic [WIDTH-1:0]            key;
  logic [NUM_LANES-1:0][7:0]   data;
  logic [NUM_LANES-1:0][7:0]   rk;
  logic [NUM_LANES-1:0][7:0]   sub;
  logic [NUM_LANES-1:0][7:0]   rotr;
  logic [NUM_LANES-1:0][7:0]   xr;

  // Round key for the round currently being undone: K rotated left by 8*(r mod 4).
  always_comb begin
    rk = key;
    case (ctr[1:0])
      2'd0: rk = key;
      2'd1: rk = {key[23:0], key[31:24]};
      2'd2: rk = {key[15:0], key[31:16]};
      2'd3: rk = {key[7:0],  key[31:8]};
      default: rk = key;
    endcase
  end

  // Byte-0 key and shift amount broadcast to every lane.
  vec_decrypt_lane u_lane [NUM_LANES-1:0] (
    .x       (data),
    .rk_lane (rk),
    .rk_b0   (rk[0]),
    .s       (shamt),
    .sub     (sub),
    .rotr    (rotr),
    .xr      (xr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ctr           <= '0;
      shamt         <= '0;
      key           <= '0;
      data          <= '0;
      bus.plain_out <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data         <= bus.cipher_in;
            key          <= bus.key_in;
            shamt        <= bus.shamt_in;
            ctr          <= bus.rounds_in - 4'd1;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            if (bus.rounds_in == 4'd0) begin
              // Zero rounds: ciphertext is already the plaintext.
              state         <= DONE;
              bus.plain_out <= bus.cipher_in;
              bus.out_valid <= 1'b1;
            end else begin
              state <= SUBK;
            end
          end
        end
        SUBK: begin
          data  <= sub;
          state <= ROTR;
        end
        ROTR: begin
          data  <= rotr;
          state <= XORK;
        end
        XORK: begin
          data <= xr;
          if (ctr == 4'd0) begin
            state         <= DONE;
            bus.plain_out <= xr;
            bus.out_valid <= 1'b1;
          end else begin
            ctr   <= ctr - 4'd1;
            state <= SUBK;
          end
        end
        DONE: begin
          // Handoff edge returns to idle only; no same-cycle re-accept.
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_decrypt_engine.sv
module tb_vec_decrypt_engine;
  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  vec_decrypt_engine_if #(.WIDTH(32)) bus ();

  vec_decrypt_engine #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] cipher;
    logic [31:0] key;
    logic [3:0]  n;
    logic [2:0]  s;
    logic [31:0] exp_plain;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Forward cipher straight from the round definition, using integer math.
  function automatic logic [31:0] encrypt(input logic [31:0] p, input logic [31:0] k,
                                          input int n, input int s);
    logic [31:0] w;
    logic [31:0] rkw;
    int x, kl;
    w = p;
    for (int r = 0; r < n; r++) begin
      rkw = (8 * (r % 4) == 0) ? k : ((k << (8 * (r % 4))) | (k >> (32 - 8 * (r % 4))));
      for (int l = 0; l < 4; l++) begin
        x  = int'((w >> (8 * l)) & 32'hFF);
        kl = int'((rkw >> (8 * l)) & 32'hFF);
        x  = x ^ int'(rkw & 32'hFF);
        x  = ((x << s) | (x >> (8 - s))) & 255;
        x  = (x + kl) % 256;
        w[8*l +: 8] = 8'(x);
      end
    end
    return w;
  endfunction

  // Called #1 after a rising edge with the engine idle.
  task automatic run_req(input logic [31:0] c, input logic [31:0] k, input logic [3:0] n,
                         input logic [2:0] s, output logic [31:0] p, output int lat);
    bus.in_valid  = 1'b1;
    bus.cipher_in = c;
    bus.key_in    = k;
    bus.rounds_in = n;
    bus.shamt_in  = s;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    // Captured values must not follow the pins after acceptance.
    bus.cipher_in = $urandom;
    bus.key_in    = $urandom;
    bus.rounds_in = 4'($urandom);
    bus.shamt_in  = 3'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus.plain_out;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  vec_t        vecs[4];
  logic [31:0] got, pt, ct, key;
  logic [3:0]  n;
  logic [2:0]  s;
  int          lat;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.cipher_in = '0; bus.key_in = '0; bus.rounds_in = '0; bus.shamt_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_plain",     bus.plain_out,      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{"lane_borrow", 32'h00000000, 32'h01010101, 4'd1, 3'd0, 32'hFEFEFEFE, 4};
    vecs[1] = '{"rotation",    32'h80402010, 32'h00000000, 4'd1, 3'd3, 32'h10080402, 4};
    vecs[2] = '{"keysched_n2", 32'h01010202, 32'h00000001, 4'd2, 3'd0, 32'h00000000, 7};
    vecs[3] = '{"keysched_s1", 32'h03030303, 32'h01010101, 4'd1, 3'd1, 32'h00000000, 4};
    foreach (vecs[i]) begin
      run_req(vecs[i].cipher, vecs[i].key, vecs[i].n, vecs[i].s, got, lat);
      check({vecs[i].name, "_plain"}, got, vecs[i].exp_plain);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
    end

    // N=0 with backpressure: result held, new requests ignored.
    bus.in_valid = 1'b1; bus.cipher_in = 32'h12345678; bus.key_in = 32'hDEADBEEF;
    bus.rounds_in = 4'd0; bus.shamt_in = 3'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_plain",     bus.plain_out,      32'h12345678);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      bus.in_valid  = (i % 2 == 0);
      bus.cipher_in = $urandom;
      @(posedge clk); #1;
    end
    // Handoff with a simultaneous request: not accepted that edge.
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.rounds_in = 4'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("handoff_in_ready", 32'(bus.in_ready),  32'd1);
    check("handoff_busy",     32'(bus.busy),      32'd0);
    check("handoff_valid",    32'(bus.out_valid), 32'd0);
    check("handoff_retain",   bus.plain_out,      32'h12345678);
    @(posedge clk); #1;
    check("no_queue_idle",    32'(bus.in_ready),  32'd1);

    // Reset in ROTR of an N=3 request, with competing handshakes.
    bus.in_valid = 1'b1; bus.cipher_in = 32'hA5A5A5A5; bus.key_in = 32'h11223344;
    bus.rounds_in = 4'd3; bus.shamt_in = 3'd2;
    @(posedge clk); #1;               // now SUBK
    bus.in_valid = 1'b0;
    @(posedge clk); #1;               // now ROTR
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_plain",     bus.plain_out,      32'd0);
    check("midrst_busy",      32'(bus.busy),      32'd0);
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    pt = 32'hCAFEF00D; key = 32'h0BADBEEF;
    ct = encrypt(pt, key, 3, 6);
    run_req(ct, key, 4'd3, 3'd6, got, lat);
    check("postrst_plain", got, pt);
    check("postrst_lat",   32'(lat), 32'd10);

    // Random round trips.
    for (int t = 0; t < 40; t++) begin
      pt  = $urandom;
      key = $urandom;
      n   = 4'($urandom_range(0, 15));
      s   = 3'($urandom_range(0, 7));
      ct  = encrypt(pt, key, int'(n), int'(s));
      run_req(ct, key, n, s, got, lat);
      check("rand_plain", got, pt);
      check("rand_lat", 32'(lat), 32'(3 * int'(n) + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vec_decrypt_engine.md
VEC_DECRYPT_ENGINE -- requirements
Module: vec_decrypt_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width; 32 is the only supported value (4 byte lanes).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have port IN_VALID, input, 1, request valid.
REQ-005 The block SHALL have port IN_READY, output, 1, block able to accept a request.
REQ-006 The block SHALL have port CIPHER_IN, input, WIDTH, ciphertext word, lanes [7:0],[15:8],[23:16],[31:24].
REQ-007 The block SHALL have port KEY_IN, input, WIDTH, base key K.
REQ-008 The block SHALL have port ROUNDS_IN, input, 4, round count N, 0..15.
REQ-009 The block SHALL have port SHAMT_IN, input, 3, per-lane circular shift amount s, 0..7.
REQ-010 The block SHALL have port OUT_VALID, output, 1, result valid.
REQ-011 The block SHALL have port OUT_READY, input, 1, consumer accepts result.
REQ-012 The block SHALL have port PLAIN_OUT, output, WIDTH, decrypted word.
REQ-013 The block SHALL have port BUSY, output, 1, high in any state other than IDLE.

Function
REQ-014 The block SHALL invert this forward round, applied for r = 0..N-1: per lane, x = x XOR RK_r[7:0] (byte 0 broadcast); x = rotate-left-8(x, s); x = (x + RK_r lane) mod 256.
REQ-015 The round key SHALL be RK_r = 32-bit rotate-left of K by 8*(r mod 4).
REQ-016 Decryption SHALL run r = N-1 down to 0, three sub-steps per round, one per cycle: SUBK (per lane, x = x - RK_r lane mod 256, no borrow across lanes); ROTR (per lane, rotate-right-8 by s); XORK (per lane, x XOR RK_r[7:0]).
REQ-017 The FSM SHALL have states IDLE, SUBK, ROTR, XORK, DONE.
REQ-018 IN_READY SHALL equal 1 only in IDLE.
REQ-019 Acceptance SHALL occur at an edge where the FSM is in IDLE and IN_VALID=1.
REQ-020 At acceptance, CIPHER_IN, KEY_IN, ROUNDS_IN and SHAMT_IN SHALL be captured; later changes on these inputs have no effect.
REQ-021 At acceptance, the round counter SHALL load N-1.
REQ-022 At acceptance, the next state SHALL be SUBK if N>0, or DONE if N=0 (PLAIN_OUT = CIPHER_IN).
REQ-023 Transitions SHALL be: SUBK->ROTR; ROTR->XORK; XORK->SUBK with counter decrement if counter>0; XORK->DONE if counter=0.
REQ-024 Latency SHALL be: OUT_VALID asserted after edge 3N+1 counting the acceptance edge as edge 1 (N=0: the cycle after acceptance).
REQ-025 In DONE, OUT_VALID SHALL be 1 and PLAIN_OUT SHALL be stable.
REQ-026 From DONE, the FSM SHALL go to IDLE at the first edge with OUT_READY=1; it SHALL hold DONE indefinitely while OUT_READY=0.
REQ-027 A new request SHALL NOT be accepted in the same cycle as the result handoff; the earliest acceptance is the edge after return to IDLE.
REQ-028 IN_VALID while BUSY=1 SHALL be ignored and SHALL NOT be queued.
REQ-029 PLAIN_OUT SHALL retain the last result after handoff until the next DONE.
REQ-030 All per-lane arithmetic SHALL wrap modulo 256 with no inter-lane carry or borrow; s=0 makes ROTR an identity step but still consumes one cycle.

Reset
REQ-031 With RST_N=0 at an edge, the block SHALL set state=IDLE, IN_READY=1, OUT_VALID=0, BUSY=0, PLAIN_OUT=0, counter=0, and clear all captured registers.
REQ-032 Reset mid-operation SHALL abandon the operation with no result produced.
REQ-033 RST_N SHALL take priority over IN_VALID and OUT_READY in the same cycle.

Verification
REQ-034 Lane borrow: CIPHER_IN=0x00000000, K=0x01010101, s=0, N=1 -> PLAIN_OUT=0xFEFEFEFE, OUT_VALID after edge 4.
REQ-035 Rotation: CIPHER_IN=0x80402010, K=0, s=3, N=1 -> PLAIN_OUT=0x10080402.
REQ-036 Key schedule: CIPHER_IN=0x01010202, K=0x00000001, s=0, N=2 -> PLAIN_OUT=0x00000000, OUT_VALID after edge 7; also CIPHER_IN=0x03030303, K=0x01010101, s=1, N=1 -> 0x00000000.
REQ-037 N=0 and backpressure: CIPHER_IN=0x12345678, N=0, OUT_READY=0 for 5 cycles -> OUT_VALID=1 with PLAIN_OUT=0x12345678 held stable throughout, IN_READY=0, IN_VALID pulses ignored; OUT_READY=1 -> IDLE at the next edge.
REQ-038 Reset mid-op: RST_N=0 asserted in ROTR of a N=3 request -> next cycle IDLE, OUT_VALID=0, PLAIN_OUT=0; a following request completes correctly.
REQ-039 Random round-trip: a reference model encrypts random words with random K, s and N=0..15 -> PLAIN_OUT equals the original plaintext, with latency 3N+1 every time.
